cp0_irq_ctrl: RTL and testbench

CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_irq_ctrl_if.sv | 37 +++
 rtl/cp0_timer.sv | 56 +++++
 rtl/cp0_irq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_cp0_irq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg -- shared definitions for the CP0 interrupt/exception controller.
//   * CP0 register numbers and select values decoded by MFC0/MTC0
//   * ExcCode enumeration and the fixed exception priority helper
//   * Status reset value and Status bit positions
package cp0_pkg;

  localparam logic [4:0] REG_BADINSTR = 5'd8;
  localparam logic [2:0] SEL_BADINSTR = 3'd1;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [2:0] SEL_DEFAULT  = 3'd0;

  localparam logic [31:0] STATUS_RESET = 32'h0000_FF01;
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_ERL = 2;

  typedef enum logic [4:0] {
    EXC_INT = 5'h00,
    EXC_SYS = 5'h08,
    EXC_BP  = 5'h09,
    EXC_RI  = 5'h0A,
    EXC_OV  = 5'h0C
  } exc_code_e;

  // Highest-priority pending exception; EXC_INT when none is raised.
  function automatic exc_code_e exc_priority(input logic ov, input logic ri,
                                             input logic sc, input logic bk);
    exc_code_e code;
    if (ov)      code = EXC_OV;
    else if (ri) code = EXC_RI;
    else if (sc) code = EXC_SYS;
    else if (bk) code = EXC_BP;
    else         code = EXC_INT;
    return code;
  endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// cp0_irq_ctrl_if -- bus between the pipeline and the CP0 controller.
//   master (pipeline): drives wr_data, regnum, sel, curr_pc, MTC0, ERET,
//                      hw_irq, overflow, reserved_inst, syscall, break_;
//                      receives rd_data, EPC, takenHandler, exc_code, timer_irq.
//   slave  (CP0)     : the mirror image.
interface cp0_irq_ctrl_if #(
  parameter int NUM_HW_IRQ = 6
);
  logic [63:0]           rd_data;
  logic [63:0]           EPC;
  logic                  takenHandler;
  logic [4:0]            exc_code;
  logic                  timer_irq;
  logic [63:0]           wr_data;
  logic [4:0]            regnum;
  logic [2:0]            sel;
  logic [63:0]           curr_pc;
  logic                  MTC0;
  logic                  ERET;
  logic [NUM_HW_IRQ-1:0] hw_irq;
  logic                  overflow;
  logic                  reserved_inst;
  logic                  syscall;
  logic                  break_;

  modport master (
    output wr_data, regnum, sel, curr_pc, MTC0, ERET, hw_irq,
           overflow, reserved_inst, syscall, break_,
    input  rd_data, EPC, takenHandler, exc_code, timer_irq
  );

  modport slave (
    input  wr_data, regnum, sel, curr_pc, MTC0, ERET, hw_irq,
           overflow, reserved_inst, syscall, break_,
    output rd_data, EPC, takenHandler, exc_code, timer_irq
  );
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer -- free-running Count, Compare and the sticky timer interrupt.
// Ports:
//   clock, reset          : system clock, async active-high reset
//   wr_count, wr_compare  : MTC0 strobes for Count / Compare
//   wr_data               : value loaded by either strobe
//   count, compare        : current register values
//   timer_irq             : set the cycle after Count == Compare,
//                           cleared only by a Compare write
module cp0_timer #(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_count,
  input  logic               wr_compare,
  input  logic [COUNT_W-1:0] wr_data,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] compare,
  output logic               timer_irq
);

  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] compare_r;
  logic               timer_irq_r;

  // Count: load on MTC0, otherwise increment with natural wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (wr_count) begin
      count_r <= wr_data;
    end else begin
      count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Compare register and sticky interrupt; writing Compare acknowledges it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      compare_r   <= '1;
      timer_irq_r <= 1'b0;
    end else if (wr_compare) begin
      compare_r   <= wr_data;
      timer_irq_r <= 1'b0;
    end else if (count_r == compare_r) begin
      timer_irq_r <= 1'b1;
    end else begin
      timer_irq_r <= timer_irq_r;
    end
  end

  assign count     = count_r;
  assign compare   = compare_r;
  assign timer_irq = timer_irq_r;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl -- CP0 interrupt and exception controller.
// Holds Status, Cause (IP + ExcCode), EPC and BadInstr, decides when the
// pipeline is redirected to the handler, and services MFC0/MTC0/ERET.
// Ports:
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : MTC0/MFC0 access, ERET, exception flags, hw_irq lines,
//                  takenHandler / EPC / exc_code / timer_irq outputs
// Optional feature: define CP0_TIMER_EN to build Count/Compare and the timer
// interrupt (cp0_timer); without it Count/Compare read 0 and timer_irq is 0.
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int         NUM_HW_IRQ = 6,
  parameter logic [5:0] EDGE_MASK  = 6'b0,
  parameter int         COUNT_W    = 32
) (
  input logic           clock,
  input logic           reset,
  cp0_irq_ctrl_if.slave bus
);

  logic [31:0] status_r;
  logic [31:0] status_nxt_s;
  exc_code_e   exc_code_r;
  logic [63:0] epc_r;
  logic [31:0] bad_instr_r;
  logic [1:0]  sw_ip_r;
  logic [5:0]  edge_ip_r;
  logic [5:0]  edge_nxt_s;
  logic [5:0]  hw_prev_r;
  logic [5:0]  hw_s;
  logic [7:0]  ip_s;
  logic [31:0] cause_s;
  logic [63:0] rd_s;
  logic [63:0] count_rd_s;
  logic [63:0] compare_rd_s;
  logic        timer_irq_s;
  logic        exception_s;
  exc_code_e   next_code_s;
  logic        take_int_s;
  logic        taken_handler_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;

  assign wr_status_s = bus.MTC0 && (bus.sel == SEL_DEFAULT) && (bus.regnum == REG_STATUS);
  assign wr_cause_s  = bus.MTC0 && (bus.sel == SEL_DEFAULT) && (bus.regnum == REG_CAUSE);
  assign wr_epc_s    = bus.MTC0 && (bus.sel == SEL_DEFAULT) && (bus.regnum == REG_EPC);

`ifdef CP0_TIMER_EN
  logic               wr_count_s;
  logic               wr_compare_s;
  logic [COUNT_W-1:0] count_s;
  logic [COUNT_W-1:0] compare_s;

  assign wr_count_s   = bus.MTC0 && (bus.sel == SEL_DEFAULT) && (bus.regnum == REG_COUNT);
  assign wr_compare_s = bus.MTC0 && (bus.sel == SEL_DEFAULT) && (bus.regnum == REG_COMPARE);

  cp0_timer #(.COUNT_W(COUNT_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .wr_count   (wr_count_s),
    .wr_compare (wr_compare_s),
    .wr_data    (bus.wr_data[COUNT_W-1:0]),
    .count      (count_s),
    .compare    (compare_s),
    .timer_irq  (timer_irq_s)
  );

  assign count_rd_s   = {{(64-COUNT_W){1'b0}}, count_s};
  assign compare_rd_s = {{(64-COUNT_W){1'b0}}, compare_s};
`else
  assign count_rd_s   = 64'd0;
  assign compare_rd_s = 64'd0;
  assign timer_irq_s  = 1'b0;
`endif

  // Widen the parameterised hw_irq bus to the fixed six IP slots.
  always_comb begin
    hw_s = 6'b000000;
    for (int i = 0; i < NUM_HW_IRQ; i++) begin
      hw_s[i] = bus.hw_irq[i];
    end
  end

  // Pending bits: software bits, then per-line level or latched edge; timer shares IP7.
  always_comb begin
    ip_s      = 8'h00;
    ip_s[1:0] = sw_ip_r;
    for (int i = 0; i < NUM_HW_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        ip_s[2+i] = edge_ip_r[i];
      end else begin
        ip_s[2+i] = hw_s[i];
      end
    end
    ip_s[7] = ip_s[7] | timer_irq_s;
  end

  assign cause_s = {16'h0000, ip_s, 1'b0, exc_code_r, 2'b00};

  assign exception_s = bus.overflow | bus.reserved_inst | bus.syscall | bus.break_;
  assign next_code_s = exc_priority(bus.overflow, bus.reserved_inst, bus.syscall, bus.break_);

  // An interrupt is not taken while an exception code is still recorded.
  assign take_int_s = (|(ip_s & status_r[15:8])) && status_r[STATUS_IE] &&
                      !status_r[STATUS_ERL] && (exc_code_r == EXC_INT);
  assign taken_handler_s = (take_int_s || exception_s) && !status_r[STATUS_EXL];

  // Status next value: MTC0 writes the word, but handler entry / ERET own EXL.
  always_comb begin
    status_nxt_s = status_r;
    if (wr_status_s) begin
      status_nxt_s = bus.wr_data[31:0];
    end else begin
      status_nxt_s = status_r;
    end
    if (taken_handler_s) begin
      status_nxt_s[STATUS_EXL] = 1'b1;
    end else if (bus.ERET) begin
      status_nxt_s[STATUS_EXL] = 1'b0;
    end else begin
      status_nxt_s[STATUS_EXL] = status_nxt_s[STATUS_EXL];
    end
  end

  // Status register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_r <= STATUS_RESET;
    end else begin
      status_r <= status_nxt_s;
    end
  end

  // Handler entry snapshot; otherwise ERET clears the code and MTC0 may load EPC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exc_code_r  <= EXC_INT;
      epc_r       <= 64'd0;
      bad_instr_r <= 32'd0;
    end else if (taken_handler_s) begin
      if (exception_s) begin
        exc_code_r  <= next_code_s;
        epc_r       <= bus.curr_pc;
        bad_instr_r <= bus.wr_data[31:0];
      end else begin
        exc_code_r  <= EXC_INT;
        epc_r       <= bus.curr_pc + 64'd4;
      end
    end else begin
      if (bus.ERET) begin
        exc_code_r <= EXC_INT;
      end
      if (wr_epc_s) begin
        epc_r <= bus.wr_data;
      end
    end
  end

  // Edge latches: a rising edge sets, a Cause write of 0 clears; set has priority.
  always_comb begin
    edge_nxt_s = edge_ip_r;
    for (int i = 0; i < 6; i++) begin
      if (EDGE_MASK[i] && (i < NUM_HW_IRQ) && hw_s[i] && !hw_prev_r[i]) begin
        edge_nxt_s[i] = 1'b1;
      end else if (wr_cause_s && !bus.wr_data[10+i]) begin
        edge_nxt_s[i] = 1'b0;
      end else begin
        edge_nxt_s[i] = edge_ip_r[i];
      end
    end
  end

  // Software IP bits, edge latches and the previous hw_irq sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_ip_r   <= 2'b00;
      edge_ip_r <= 6'b000000;
      hw_prev_r <= 6'b000000;
    end else begin
      if (wr_cause_s) begin
        sw_ip_r <= bus.wr_data[9:8];
      end
      edge_ip_r <= edge_nxt_s;
      hw_prev_r <= hw_s;
    end
  end

  // MFC0 read mux; unmapped register numbers read zero.
  always_comb begin
    rd_s = 64'd0;
    if (bus.sel == SEL_DEFAULT) begin
      case (bus.regnum)
        REG_STATUS:  rd_s = {32'd0, status_r};
        REG_CAUSE:   rd_s = {32'd0, cause_s};
        REG_EPC:     rd_s = epc_r;
        REG_COUNT:   rd_s = count_rd_s;
        REG_COMPARE: rd_s = compare_rd_s;
        default:     rd_s = 64'd0;
      endcase
    end else if ((bus.sel == SEL_BADINSTR) && (bus.regnum == REG_BADINSTR)) begin
      rd_s = {32'd0, bad_instr_r};
    end else begin
      rd_s = 64'd0;
    end
  end

  assign bus.rd_data      = rd_s;
  assign bus.EPC          = epc_r;
  assign bus.takenHandler = taken_handler_s;
  assign bus.exc_code     = exc_code_r;
  assign bus.timer_irq    = timer_irq_s;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Self-checking bench for cp0_irq_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the CP0 rules.
module tb_cp0_irq_ctrl;

  localparam logic [5:0] EM = 6'b000101;
  localparam int CW = 16;
  localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cp0_irq_ctrl_if #(.NUM_HW_IRQ(6)) bus();

  cp0_irq_ctrl #(.NUM_HW_IRQ(6), .EDGE_MASK(EM), .COUNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0]     m_status;
  logic [4:0]      m_exc;
  logic [63:0]     m_epc;
  logic [31:0]     m_bad;
  logic [1:0]      m_sw;
  bit              m_edge [6];
  bit              m_prev [6];
  longint unsigned m_count;
  longint unsigned m_compare;
  bit              m_timer;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_status  = 32'h0000_FF01;
    m_exc     = 5'd0;
    m_epc     = 64'd0;
    m_bad     = 32'd0;
    m_sw      = 2'd0;
    m_count   = 0;
    m_compare = CMASK;
    m_timer   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_edge[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
  endtask

  function automatic logic [7:0] m_ip();
    logic [7:0] ip;
    ip = {6'd0, m_sw};
    for (int i = 0; i < 6; i++)
      if (EM[i] ? m_edge[i] : bus.hw_irq[i]) ip = ip | (8'd1 << (2 + i));
    if (m_timer) ip = ip | 8'h80;
    return ip;
  endfunction

  function automatic logic [4:0] m_code();
    if (bus.overflow)      return 5'd12;
    if (bus.reserved_inst) return 5'd10;
    if (bus.syscall)       return 5'd8;
    if (bus.break_)        return 5'd9;
    return 5'd0;
  endfunction

  function automatic bit m_taken();
    bit irq;
    irq = ((m_ip() & m_status[15:8]) != 8'd0) && m_status[0] && !m_status[2] && (m_exc == 5'd0);
    return (irq || (m_code() != 5'd0)) && !m_status[1];
  endfunction

  function automatic logic [63:0] m_read();
    if (bus.sel == 3'd1 && bus.regnum == 5'd8) return {32'd0, m_bad};
    if (bus.sel != 3'd0) return 64'd0;
    case (bus.regnum)
      5'd12:   return {32'd0, m_status};
      5'd13:   return (64'(m_ip()) << 8) | (64'(m_exc) << 2);
      5'd14:   return m_epc;
`ifdef CP0_TIMER_EN
      5'd9:    return m_count;
      5'd11:   return m_compare;
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit mtc0_to(input logic [4:0] r);
    return bus.MTC0 && bus.sel == 3'd0 && bus.regnum == r;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic m_update();
    logic [4:0]  code;
    bit          taken;
    logic [31:0] st;
    if (reset) begin
      m_reset();
      return;
    end
    code  = m_code();
    taken = m_taken();
    st    = mtc0_to(5'd12) ? bus.wr_data[31:0] : m_status;
    if (taken)         st[1] = 1'b1;
    else if (bus.ERET) st[1] = 1'b0;
    if (taken)              m_epc = (code != 5'd0) ? bus.curr_pc : bus.curr_pc + 64'd4;
    else if (mtc0_to(5'd14)) m_epc = bus.wr_data;
    if (taken && code != 5'd0) m_bad = bus.wr_data[31:0];
    if (taken)         m_exc = code;
    else if (bus.ERET) m_exc = 5'd0;
    for (int i = 0; i < 6; i++) begin
      if (EM[i] && bus.hw_irq[i] && !m_prev[i])                m_edge[i] = 1'b1;
      else if (mtc0_to(5'd13) && !bus.wr_data[10+i])           m_edge[i] = 1'b0;
      m_prev[i] = bus.hw_irq[i];
    end
    if (mtc0_to(5'd13)) m_sw = bus.wr_data[9:8];
`ifdef CP0_TIMER_EN
    if (mtc0_to(5'd11))              m_timer = 1'b0;
    else if (m_count == m_compare)   m_timer = 1'b1;
`endif
    if (mtc0_to(5'd11)) m_compare = bus.wr_data & CMASK;
    m_count = mtc0_to(5'd9) ? (bus.wr_data & CMASK) : ((m_count + 1) & CMASK);
    m_status = st;
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic settle();
    #1;
    if (reset) m_reset();
    chk("takenHandler", bus.takenHandler, m_taken());
    chk("rd_data", bus.rd_data, m_read());
    chk("EPC", bus.EPC, m_epc);
    chk("exc_code", bus.exc_code, m_exc);
    chk("timer_irq", bus.timer_irq, m_timer);
  endtask

  task automatic advance();
    @(posedge clock);
    m_update();
    @(negedge clock);
  endtask

  task automatic idle();
    bus.MTC0 = 1'b0; bus.ERET = 1'b0;
    bus.overflow = 1'b0; bus.reserved_inst = 1'b0; bus.syscall = 1'b0; bus.break_ = 1'b0;
    bus.regnum = 5'd0; bus.sel = 3'd0; bus.wr_data = 64'd0; bus.curr_pc = 64'd0;
  endtask

  task automatic rd(input logic [4:0] r, input logic [2:0] s);
    bus.regnum = r; bus.sel = s;
  endtask

  initial begin
    int r;
    idle();
    bus.hw_irq = 6'd0;
    m_reset();
    @(negedge clock);

    // Reset values
    idle(); rd(5'd12, 3'd0); settle();
    chk("reset_status", bus.rd_data, 64'h0000_FF01);
    advance();
    idle(); rd(5'd13, 3'd0); settle();
    chk("reset_cause", bus.rd_data, 64'd0);
    reset = 1'b0;
    advance();

    // Overflow exception and ERET
    idle(); bus.overflow = 1'b1; bus.curr_pc = 64'h400; settle();
    chk("ov_taken", bus.takenHandler, 64'd1);
    advance();
    idle(); rd(5'd13, 3'd0); settle();
    chk("ov_epc", bus.EPC, 64'h400);
    chk("ov_cause", bus.rd_data, 64'h30);
    advance();
    idle(); rd(5'd12, 3'd0); settle();
    chk("ov_exl", bus.rd_data, 64'h0000_FF03);
    advance();
    idle(); bus.ERET = 1'b1; settle(); advance();
    idle(); rd(5'd13, 3'd0); settle();
    chk("eret_cause", bus.rd_data, 64'd0);
    advance();
    idle(); rd(5'd12, 3'd0); settle();
    chk("eret_status", bus.rd_data, 64'h0000_FF01);
    advance();

    // Priority, then exception while EXL set
    idle(); bus.overflow = 1'b1; bus.syscall = 1'b1; bus.curr_pc = 64'h500; settle(); advance();
    idle(); settle();
    chk("prio_code", bus.exc_code, 64'h0C);
    advance();
    idle(); bus.syscall = 1'b1; bus.curr_pc = 64'h600; settle();
    chk("exl_block", bus.takenHandler, 64'd0);
    advance();
    idle(); settle();
    chk("exl_epc", bus.EPC, 64'h500);
    advance();
    idle(); bus.ERET = 1'b1; settle(); advance();

    // Handler wins over MTC0 EPC
    idle(); bus.MTC0 = 1'b1; bus.regnum = 5'd14; bus.wr_data = 64'h800;
    bus.syscall = 1'b1; bus.curr_pc = 64'h200; settle(); advance();
    idle(); rd(5'd8, 3'd1); settle();
    chk("mtc0_epc_lose", bus.EPC, 64'h200);
    chk("sys_code", bus.exc_code, 64'h08);
    chk("badinstr", bus.rd_data, 64'h800);
    advance();
    idle(); bus.ERET = 1'b1; settle(); advance();

    // Edge-latched line 0
    idle(); bus.hw_irq[0] = 1'b1; bus.curr_pc = 64'h100; settle();
    chk("edge_not_yet", bus.takenHandler, 64'd0);
    advance();
    bus.hw_irq[0] = 1'b0; bus.curr_pc = 64'h100; settle();
    chk("edge_taken", bus.takenHandler, 64'd1);
    advance();
    idle(); rd(5'd13, 3'd0); settle();
    chk("edge_epc", bus.EPC, 64'h104);
    chk("edge_ip2", bus.rd_data, 64'h400);
    advance();
    idle(); bus.MTC0 = 1'b1; bus.regnum = 5'd13; bus.wr_data = 64'd0; settle(); advance();
    idle(); rd(5'd13, 3'd0); settle();
    chk("edge_clear", bus.rd_data, 64'd0);
    advance();
    idle(); bus.ERET = 1'b1; settle(); advance();

`ifdef CP0_TIMER_EN
    // Timer: Compare=5, Count=0 -> set on 6th edge after the load
    idle(); bus.MTC0 = 1'b1; bus.regnum = 5'd11; bus.wr_data = 64'd5; settle(); advance();
    idle(); bus.MTC0 = 1'b1; bus.regnum = 5'd9; bus.wr_data = 64'd0; settle(); advance();
    for (int k = 0; k < 6; k++) begin
      idle(); settle();
      chk("timer_wait", bus.timer_irq, 64'd0);
      advance();
    end
    idle(); rd(5'd13, 3'd0); settle();
    chk("timer_set", bus.timer_irq, 64'd1);
    chk("timer_cause", bus.rd_data, 64'h8000);
    advance();
    idle(); bus.MTC0 = 1'b1; bus.regnum = 5'd11; bus.wr_data = 64'hFFFF; bus.ERET = 1'b1;
    settle(); advance();
    idle(); settle();
    chk("timer_clear", bus.timer_irq, 64'd0);
    advance();
`endif

    // Reset mid-handler aborts the update
    idle(); bus.overflow = 1'b1; bus.curr_pc = 64'h900; settle();
    reset = 1'b1; #1; m_reset();
    advance();
    reset = 1'b0;
    idle(); rd(5'd12, 3'd0); settle();
    chk("rst_abort_epc", bus.EPC, 64'd0);
    chk("rst_abort_status", bus.rd_data, 64'h0000_FF01);
    advance();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      bus.overflow      = ($urandom_range(0, 15) == 0);
      bus.reserved_inst = ($urandom_range(0, 15) == 0);
      bus.syscall       = ($urandom_range(0, 15) == 0);
      bus.break_        = ($urandom_range(0, 15) == 0);
      bus.ERET          = ($urandom_range(0, 9) == 0);
      bus.MTC0          = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 7);
      case (r)
        0: bus.regnum = 5'd8;  1: bus.regnum = 5'd9;  2: bus.regnum = 5'd11;
        3: bus.regnum = 5'd12; 4: bus.regnum = 5'd13; 5: bus.regnum = 5'd14;
        6: bus.regnum = 5'd3;  default: bus.regnum = 5'd0;
      endcase
      bus.sel = (bus.regnum == 5'd8 || $urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
      bus.wr_data = {$urandom, $urandom};
      bus.curr_pc = {$urandom, $urandom};
      if (bus.regnum == 5'd12) begin
        bus.wr_data[2] = ($urandom_range(0, 7) == 0);
        bus.wr_data[0] = ($urandom_range(0, 7) != 0);
      end
      if (bus.regnum == 5'd11) bus.wr_data = (m_count + $urandom_range(0, 30)) & CMASK;
      if (bus.regnum == 5'd9 && $urandom_range(0, 1) == 0) bus.wr_data = CMASK - $urandom_range(0, 4);
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 5) == 0) bus.hw_irq[i] = ~bus.hw_irq[i];
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
